// File: rtl/clock_divider.sv
// Clock-enable generator: derives registered, glitch-free slow square waves
// (VGA, UART, LED-matrix, debounce) from clk, with run-time VGA/UART ratios.
module clock_divider #(
    parameter int UART_HALF = 8,
    parameter int LM_HALF   = 32,
    parameter int DB_HALF   = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkinVGA,
    input  logic       c_valid,
    input  logic [3:0] c_addr,
    input  logic [7:0] c_data,
    output logic       c_ready,
    output logic       clk_VGA,
    output logic       clk_UART,
    output logic       clk_LM,
    output logic       clk_DB
);

    localparam logic [3:0] VGA_ADDR  = 4'b0100;
    localparam logic [3:0] UART_ADDR = 4'b1000;

    // UART counter must reach the largest half-period (UART_SEL = 3).
    localparam int UART_MAX = UART_HALF << 3;
    localparam int UART_W   = $clog2(UART_MAX + 1);

    // ------------------------------------------------------------------
    // Configuration port
    // ------------------------------------------------------------------
    logic       armed_reg;
    logic       c_ready_reg;
    logic [2:0] vga_sel_reg;
    logic [1:0] uart_sel_reg;
    logic       accept;
    logic       wr_vga;
    logic       wr_uart;

    assign accept  = c_valid && armed_reg;
    assign wr_vga  = accept && (c_addr == VGA_ADDR);
    assign wr_uart = accept && (c_addr == UART_ADDR);

    // A held c_valid produces one write; re-arm only after c_valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_reg    <= 1'b1;
            c_ready_reg  <= 1'b0;
            vga_sel_reg  <= 3'd0;
            uart_sel_reg <= 2'd0;
        end else begin
            c_ready_reg <= 1'b0;
            if (accept) begin
                armed_reg   <= 1'b0;
                c_ready_reg <= 1'b1;
                if (wr_vga) begin
                    vga_sel_reg <= c_data[4:2];
                end
                if (wr_uart) begin
                    uart_sel_reg <= c_data[4:3];
                end
            end else if (!c_valid) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign c_ready = c_ready_reg;

    // ------------------------------------------------------------------
    // VGA path: synchronizer, rising-edge detector, power-of-two divider
    // ------------------------------------------------------------------
    logic [1:0] vga_sync_reg;
    logic       vga_prev_reg;
    logic       vga_rise;
    logic [6:0] vga_cnt_reg;
    logic [6:0] vga_cnt_next;
    logic [6:0] vga_last;
    logic       clk_vga_reg;
    logic       clk_vga_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_sync_reg <= 2'b00;
            vga_prev_reg <= 1'b0;
        end else begin
            vga_sync_reg <= {vga_sync_reg[0], clkinVGA};
            vga_prev_reg <= vga_sync_reg[1];
        end
    end

    assign vga_rise = vga_sync_reg[1] && !vga_prev_reg;

    // Half-period of 2^(n-1) detected edges; last count value is that minus one.
    always_comb begin
        vga_last = 7'd0;
        if (vga_sel_reg != 3'd0) begin
            vga_last = (7'd1 << (vga_sel_reg - 3'd1)) - 7'd1;
        end
    end

    always_comb begin
        vga_cnt_next = vga_cnt_reg;
        clk_vga_next = clk_vga_reg;
        if (vga_sel_reg == 3'd0) begin
            vga_cnt_next = 7'd0;
            clk_vga_next = vga_sync_reg[1];
        end else if (vga_rise) begin
            if (vga_cnt_reg == vga_last) begin
                vga_cnt_next = 7'd0;
                clk_vga_next = !clk_vga_reg;
            end else begin
                vga_cnt_next = vga_cnt_reg + 7'd1;
            end
        end
        // Ratio change restarts the count but leaves the level alone.
        if (wr_vga) begin
            vga_cnt_next = 7'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_cnt_reg <= 7'd0;
            clk_vga_reg <= 1'b0;
        end else begin
            vga_cnt_reg <= vga_cnt_next;
            clk_vga_reg <= clk_vga_next;
        end
    end

    assign clk_VGA = clk_vga_reg;

    // ------------------------------------------------------------------
    // UART path: half-period UART_HALF << UART_SEL clk cycles
    // ------------------------------------------------------------------
    logic [UART_W-1:0] uart_cnt_reg;
    logic [UART_W-1:0] uart_cnt_next;
    logic [UART_W-1:0] uart_last;
    logic              clk_uart_reg;
    logic              clk_uart_next;
    int                uart_half;

    always_comb begin
        uart_half = UART_HALF << uart_sel_reg;
        uart_last = UART_W'(uart_half - 1);
    end

    always_comb begin
        uart_cnt_next = uart_cnt_reg + UART_W'(1);
        clk_uart_next = clk_uart_reg;
        if (uart_cnt_reg == uart_last) begin
            uart_cnt_next = '0;
            clk_uart_next = !clk_uart_reg;
        end
        if (wr_uart) begin
            uart_cnt_next = '0;
            clk_uart_next = clk_uart_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_cnt_reg <= '0;
            clk_uart_reg <= 1'b0;
        end else begin
            uart_cnt_reg <= uart_cnt_next;
            clk_uart_reg <= clk_uart_next;
        end
    end

    assign clk_UART = clk_uart_reg;

    // ------------------------------------------------------------------
    // Fixed-ratio paths: index 0 = LED matrix, index 1 = debounce
    // ------------------------------------------------------------------
    logic [1:0] fixed_out;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fixed
        localparam int HALF = (gi == 0) ? LM_HALF : DB_HALF;
        localparam int W    = (HALF > 1) ? $clog2(HALF) : 1;

        logic [W-1:0] cnt_reg;
        logic         out_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_reg <= '0;
                out_reg <= 1'b0;
            end else if (cnt_reg == W'(HALF - 1)) begin
                cnt_reg <= '0;
                out_reg <= !out_reg;
            end else begin
                cnt_reg <= cnt_reg + W'(1);
            end
        end

        assign fixed_out[gi] = out_reg;
    end

    assign clk_LM = fixed_out[0];
    assign clk_DB = fixed_out[1];

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider: reset state, default periods, VGA/UART
// ratio writes, handshake pulses and mid-run reset.
module tb_clock_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clkinVGA = 1'b0;
    logic       c_valid = 1'b0;
    logic [3:0] c_addr = 4'd0;
    logic [7:0] c_data = 8'd0;
    logic       c_ready;
    logic       clk_VGA;
    logic       clk_UART;
    logic       clk_LM;
    logic       clk_DB;

    int total = 0;
    int bad = 0;

    clock_divider #(
        .UART_HALF(8),
        .LM_HALF(32),
        .DB_HALF(1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clkinVGA(clkinVGA),
        .c_valid(c_valid),
        .c_addr(c_addr),
        .c_data(c_data),
        .c_ready(c_ready),
        .clk_VGA(clk_VGA),
        .clk_UART(clk_UART),
        .clk_LM(clk_LM),
        .clk_DB(clk_DB)
    );

    // 250 MHz system clock: rising edges at 4k+2 ns.
    initial forever #2 clk = ~clk;

    // 312 ns VGA reference; edges at odd ns so they never coincide with clk.
    initial begin
        #1;
        forever begin
            clkinVGA = ~clkinVGA;
            #156;
        end
    end

    task automatic check(input string tag, input int observed, input int expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, observed, expected);
        end else begin
            $display("ok   %s: %0d", tag, observed);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return clk_VGA;
            1:       return clk_UART;
            2:       return clk_LM;
            3:       return clk_DB;
            default: return c_ready;
        endcase
    endfunction

    // Cycles (negedge samples) until the selected output is seen rising; -1 on timeout.
    task automatic wait_rise(input int which, input int budget, output int n);
        logic prev;
        logic cur;
        logic done;
        prev = sig(which);
        done = 1'b0;
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            if (!done) begin
                @(negedge clk);
                cur = sig(which);
                if (!prev && cur) begin
                    n = i;
                    done = 1'b1;
                end
                prev = cur;
            end
        end
    endtask

    task automatic measure_period(input string tag, input int which, input int budget,
                                  input int expected);
        int n;
        wait_rise(which, budget, n);
        wait_rise(which, budget, n);
        check(tag, n, expected);
    endtask

    // Holds c_valid for 'hold' cycles, then watches 4 more; counts c_ready pulses
    // and clk_VGA level changes seen after the acknowledge.
    task automatic write_cfg(input logic [3:0] a, input logic [7:0] d, input int hold,
                             output int pulses, output int first, output int vga_chg);
        logic prev_vga;
        @(negedge clk);
        c_addr = a;
        c_data = d;
        c_valid = 1'b1;
        pulses = 0;
        first = 0;
        vga_chg = 0;
        prev_vga = 1'b0;
        for (int i = 1; i <= hold + 4; i++) begin
            @(negedge clk);
            if (c_ready) pulses++;
            if (i == 1) begin
                first = int'(c_ready);
                prev_vga = clk_VGA;
            end else if (clk_VGA != prev_vga) begin
                vga_chg++;
                prev_vga = clk_VGA;
            end
            if (i == hold) c_valid = 1'b0;
        end
        $display("write addr=%h data=%h hold=%0d pulses=%0d", a, d, hold, pulses);
    endtask

    initial begin
        int p;
        int f;
        int ch;
        int n;
        int first_uart;
        int first_lm;
        int first_db;
        int ready_cnt;

        // Reset state
        #10;
        @(negedge clk);
        check("rst_c_ready", c_ready, 0);
        check("rst_vga", clk_VGA, 0);
        check("rst_uart", clk_UART, 0);
        check("rst_lm", clk_LM, 0);
        check("rst_db", clk_DB, 0);
        rst = 1'b0;

        // First rises after release
        first_uart = 0;
        first_lm = 0;
        first_db = 0;
        ready_cnt = 0;
        for (int i = 1; i <= 1100; i++) begin
            @(negedge clk);
            if (first_uart == 0 && clk_UART) first_uart = i;
            if (first_lm == 0 && clk_LM) first_lm = i;
            if (first_db == 0 && clk_DB) first_db = i;
            if (c_ready) ready_cnt++;
        end
        check("first_uart", first_uart, 8);
        check("first_lm", first_lm, 32);
        check("first_db", first_db, 1024);
        check("idle_c_ready", ready_cnt, 0);

        // Default periods
        measure_period("per_uart_def", 1, 200, 16);
        measure_period("per_lm", 2, 200, 64);
        measure_period("per_db", 3, 2200, 2048);
        measure_period("per_vga_pass", 0, 200, 78);

        // Pass-through lag: third clk edge after the reference rises
        @(posedge clkinVGA);
        n = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (n < 0 && clk_VGA) n = i;
        end
        check("vga_lag", n, 3);

        // VGA divide by 16 with a long c_valid
        write_cfg(4'b0100, 8'h10, 78, p, f, ch);
        check("vga16_pulses", p, 1);
        check("vga16_first", f, 1);
        check("vga16_no_runt", ch, 0);
        measure_period("per_vga16", 0, 2600, 1248);

        // VGA divide by 4, then back to pass-through
        write_cfg(4'b0100, 8'h08, 2, p, f, ch);
        check("vga4_pulses", p, 1);
        measure_period("per_vga4", 0, 700, 312);
        write_cfg(4'b0100, 8'h00, 2, p, f, ch);
        measure_period("per_vga_back", 0, 200, 78);

        // Ignored data bits on the VGA register keep pass-through
        write_cfg(4'b0100, 8'hE3, 1, p, f, ch);
        check("vga_ign_pulses", p, 1);
        measure_period("per_vga_ign", 0, 200, 78);

        // UART ratio changes
        write_cfg(4'b1000, 8'h10, 2, p, f, ch);
        check("uart2_pulses", p, 1);
        measure_period("per_uart2", 1, 200, 64);
        write_cfg(4'b1000, 8'h00, 2, p, f, ch);
        measure_period("per_uart0", 1, 200, 16);

        // Unmapped address: acknowledged, nothing changes
        write_cfg(4'b0001, 8'hFF, 3, p, f, ch);
        check("unmapped_pulses", p, 1);
        measure_period("per_uart_unm", 1, 200, 16);
        measure_period("per_vga_unm", 0, 200, 78);

        // Reset while clk_UART is high at UART_SEL=2, with a competing write
        write_cfg(4'b1000, 8'h10, 2, p, f, ch);
        wait_rise(1, 200, n);
        check("pre_rst_uart_high", clk_UART, 1);
        rst = 1'b1;
        c_addr = 4'b1000;
        c_data = 8'h18;
        c_valid = 1'b1;
        #1;
        check("mid_rst_c_ready", c_ready, 0);
        check("mid_rst_vga", clk_VGA, 0);
        check("mid_rst_uart", clk_UART, 0);
        check("mid_rst_lm", clk_LM, 0);
        check("mid_rst_db", clk_DB, 0);
        @(negedge clk);
        @(negedge clk);
        c_valid = 1'b0;
        rst = 1'b0;
        wait_rise(1, 100, n);
        check("post_rst_first_uart", n, 8);
        measure_period("post_rst_uart", 1, 200, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_divider.md
# clock_divider

Central clock-enable generator that turns the 250 MHz system clock and an external VGA reference into four slow, glitch-free square waves. These are clk_VGA, clk_UART, clk_LM (LED matrix) and clk_DB (debounce). A small write-only configuration port selects the VGA and UART division ratios at run time. Consumers sample the outputs as ordinary clk-domain signals.

## Interface
- UART_HALF, 8: base half-period of clk_UART in clk cycles (≥1)
- LM_HALF, 32: half-period of clk_LM in clk cycles (≥1)
- DB_HALF, 1024: half-period of clk_DB in clk cycles (≥1)
- clk  input  1  system clock (nominal 250 MHz); all logic on its rising edge
- rst  input  1  reset, asynchronous, active-high
- clkinVGA  input  1  external VGA reference (nominal 312 ns period), asynchronous to clk
- c_valid  input  1  config write request (level)
- c_addr  input  4  config register address
- c_data  input  8  config write data
- c_ready  output  1  one-cycle write acknowledge
- clk_VGA  output  1  divided VGA clock
- clk_UART  output  1  divided UART clock
- clk_LM  output  1  fixed LED-matrix clock
- clk_DB  output  1  fixed debounce clock

## Operation
- Config registers (reset 0):
  - VGA_SEL[2:0], at c_addr=4'b0100, loaded from c_data[4:2].
  - UART_SEL[1:0], at c_addr=4'b1000, loaded from c_data[4:3].
  - Other c_data bits are ignored.
- Handshake:
  - A write is accepted on the first clk edge where c_valid=1 and the port is armed. The register loads on that edge, and c_ready=1 for exactly the following cycle.
  - The port then disarms and re-arms once c_valid is sampled 0. One long c_valid pulse therefore produces exactly one write and one c_ready pulse.
  - An unmapped address is still acknowledged (c_ready pulses) but changes no register.
- VGA path:
  - clkinVGA passes through a 2-flop synchronizer, then a rising-edge detector.
  - VGA_SEL=0: clk_VGA equals the synchronized clkinVGA.
  - VGA_SEL=n>0: clk_VGA = synchronized clkinVGA divided by 2^n. An n-bit counter increments on each detected rising edge, and clk_VGA toggles when it wraps at 2^(n-1) edges.
- UART path: a counter counts clk cycles from 0 to H-1, where H = UART_HALF << UART_SEL. At H-1 it wraps to 0 and clk_UART toggles. UART_SEL 0..3 gives periods of 2H: 16, 32, 64, 128 cycles with defaults.
- LM / DB paths: same counter scheme with fixed LM_HALF / DB_HALF.
- Ratio change: a write to VGA_SEL or UART_SEL clears that path's counter on the write edge. The output keeps its current level, so no runt pulse shorter than the new half-period is produced.
- Outputs are registered; no combinational clock gating.

## Timing
- Reset values:
  - Outputs: all 0 (c_ready, clk_VGA, clk_UART, clk_LM, clk_DB).
  - Internal state: counters 0, VGA_SEL=0, UART_SEL=0, synchronizer 0, port armed.
- Reset mid-operation returns everything to the reset state immediately and asynchronously. Counting restarts from 0 at the first edge after rst falls.
- First toggle after reset release:
  - clk_UART rises after UART_HALF edges (8).
  - clk_LM rises after 32 edges.
  - clk_DB rises after 1024 edges.
- c_ready latency: 1 cycle after the accepting edge; width 1 cycle.
- New ratio takes effect on the write edge; the first toggle at the new ratio comes one new half-period later.
- clk_VGA in pass-through lags clkinVGA by 2–3 clk cycles. In divided mode it changes 1 cycle after the detected edge.
- Simultaneous c_valid with rst: rst wins; no write.

## Test plan
- Reset, then run 20 µs with no writes:
  - clk_UART period 16 cycles (64 ns), clk_LM 64 cycles, clk_DB 2048 cycles.
  - clk_VGA follows clkinVGA (312 ns period) with 2–3 cycle lag.
  - c_ready stays 0.
- Write c_addr=4'b0100, c_data[4:2]=3'b100 with c_valid held 312 ns:
  - exactly one c_ready pulse;
  - clk_VGA period becomes 16×312 = 4992 ns, no short pulse.
- Write 4'b0100 with 3'b010 → clk_VGA period 1248 ns. Then write 4'b0100 with 3'b000 → pass-through restored.
- Write c_addr=4'b1000, c_data[4:3]=2'b10 → clk_UART period 64 cycles (256 ns). Then write 2'b00 → 16 cycles.
- Write unmapped c_addr=4'b0001 → c_ready pulses once; all output periods unchanged.
- Assert rst for 8 ns during clk_UART high after UART_SEL=2 → all outputs 0 at once, UART_SEL=0, and clk_UART rises 8 cycles after release.
